// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select with RAW forwarding and load-use bubbles.
// Build option: define ID_EX_FWD_EN to enable the EX/MEM and MEM/WB forward muxes.
`timescale 1ns/1ps
module id_ex_stage #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [15:0]    id_imm,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_wr_idx,
  input  logic [OPW-1:0] id_alu_operation,
  input  logic           id_alu_src,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           id_mem_write,
  input  logic           id_mem_to_reg,
  input  logic           stall,
  input  logic           flush,
  input  logic           exm_reg_write,
  input  logic [RW-1:0]  exm_wr_idx,
  input  logic [DW-1:0]  exm_result,
  input  logic           wb_reg_write,
  input  logic [RW-1:0]  wb_wr_idx,
  input  logic [DW-1:0]  wb_data,
  output logic [DW-1:0]  in1,
  output logic [DW-1:0]  in2,
  output logic [OPW-1:0] alu_operation,
  output logic [DW-1:0]  ex_store_data,
  output logic           ex_valid,
  output logic [RW-1:0]  ex_wr_idx,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic           ex_mem_write,
  output logic           ex_mem_to_reg,
  output logic           hazard_hold
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);

  // Latched operand state: source indices and register-file values for the forward muxes.
  logic [RW-1:0] rs_idx;
  logic [RW-1:0] rt_idx;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [15:0]   imm_q;
  logic          alu_src_q;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          rt_used;
  logic          kill;

  // rt is a true source unless the immediate replaces it, except for stores which read it.
  assign rt_used = !id_alu_src || id_mem_write;

`ifdef ID_EX_FWD_EN
  always_comb begin
    fwd_rs = rs_val;
    if (rs_idx != '0) begin
      if (exm_reg_write && exm_wr_idx == rs_idx)     fwd_rs = exm_result;
      else if (wb_reg_write && wb_wr_idx == rs_idx)  fwd_rs = wb_data;
    end
  end

  always_comb begin
    fwd_rt = rt_val;
    if (rt_idx != '0) begin
      if (exm_reg_write && exm_wr_idx == rt_idx)     fwd_rt = exm_result;
      else if (wb_reg_write && wb_wr_idx == rt_idx)  fwd_rt = wb_data;
    end
  end

  // Only a load still in EX cannot be covered by forwarding.
  always_comb begin
    hazard_hold = id_valid && ex_valid && ex_mem_read && (ex_wr_idx != '0) &&
                  ((ex_wr_idx == id_rs) || (rt_used && ex_wr_idx == id_rt));
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_result, wb_reg_write, wb_wr_idx, wb_data};
  assign fwd_rs = rs_val;
  assign fwd_rt = rt_val;

  // Without forwarding, any producer still ahead of the register-file write must drain first.
  always_comb begin
    hazard_hold = 1'b0;
    if (id_valid) begin
      if (id_rs != '0 &&
          ((ex_valid && ex_reg_write && ex_wr_idx == id_rs) ||
           (exm_reg_write && exm_wr_idx == id_rs)))
        hazard_hold = 1'b1;
      if (rt_used && id_rt != '0 &&
          ((ex_valid && ex_reg_write && ex_wr_idx == id_rt) ||
           (exm_reg_write && exm_wr_idx == id_rt)))
        hazard_hold = 1'b1;
    end
  end
`endif

  // Handshake: hazard_hold asks IF/ID to keep its instruction; stall freezes this stage
  // unless flush or a load-use bubble overrides it on the same edge.
  assign kill = flush || hazard_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (kill) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_valid && id_reg_write;
      ex_mem_read   <= id_valid && id_mem_read;
      ex_mem_write  <= id_valid && id_mem_write;
      ex_mem_to_reg <= id_valid && id_mem_to_reg;
    end
  end

  // While held, operands absorb forwarded values so a producer leaving WB is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_idx        <= '0;
      rt_idx        <= '0;
      rs_val        <= '0;
      rt_val        <= '0;
      imm_q         <= '0;
      alu_src_q     <= 1'b0;
      alu_operation <= OP_ADD;
      ex_wr_idx     <= '0;
    end else if (kill || !stall) begin
      rs_idx        <= id_rs;
      rt_idx        <= id_rt;
      rs_val        <= id_rs_data;
      rt_val        <= id_rt_data;
      imm_q         <= id_imm;
      alu_src_q     <= id_alu_src;
      alu_operation <= id_alu_operation;
      ex_wr_idx     <= id_wr_idx;
    end else begin
      rs_val        <= fwd_rs;
      rt_val        <= fwd_rt;
    end
  end

  assign in1           = fwd_rs;
  assign in2           = alu_src_q ? {{(DW-16){imm_q[15]}}, imm_q} : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, hand sequences and a random run
// checked against a behavioural model of the stage.
`timescale 1ns/1ps
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_wr_idx;
  logic [3:0]  id_alu_operation;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        exm_reg_write;
  logic [4:0]  exm_wr_idx;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_wr_idx;
  logic [31:0] wb_data;
  logic [31:0] in1, in2, ex_store_data;
  logic [3:0]  alu_operation;
  logic        ex_valid;
  logic [4:0]  ex_wr_idx;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        hazard_hold;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_wr_idx(id_wr_idx),
    .id_alu_operation(id_alu_operation), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_wr_idx(exm_wr_idx), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_wr_idx(wb_wr_idx), .wb_data(wb_data),
    .in1(in1), .in2(in2), .alu_operation(alu_operation), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_wr_idx(ex_wr_idx), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .hazard_hold(hazard_hold)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
  endtask

  // behavioural model: what instruction EX currently holds
  typedef struct {
    bit          valid, rw, mr, mw, m2r, src;
    logic [4:0]  wr, rs, rt;
    logic [3:0]  op;
    logic [31:0] rsv, rtv;
    logic [15:0] imm;
  } ex_t;

  ex_t m;

  function automatic ex_t m_reset();
    ex_t n;
    n = '{valid: 0, rw: 0, mr: 0, mw: 0, m2r: 0, src: 0, wr: 0, rs: 0, rt: 0,
          op: 4'b0010, rsv: 0, rtv: 0, imm: 0};
    return n;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] latched);
    if (FWD && idx != 0) begin
      if (exm_reg_write && exm_wr_idx == idx) return exm_result;
      if (wb_reg_write && wb_wr_idx == idx) return wb_data;
    end
    return latched;
  endfunction

  function automatic bit m_hazard();
    logic [4:0] srcs[$];
    if (!id_valid) return 1'b0;
    srcs.push_back(id_rs);
    if (!id_alu_src || id_mem_write) srcs.push_back(id_rt);
    foreach (srcs[i]) begin
      if (srcs[i] == 0) continue;
      if (FWD) begin
        if (m.valid && m.mr && m.wr == srcs[i]) return 1'b1;
      end else begin
        if (m.valid && m.rw && m.wr == srcs[i]) return 1'b1;
        if (exm_reg_write && exm_wr_idx == srcs[i]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic ex_t from_id();
    ex_t n;
    n.valid = id_valid;
    n.rw = id_valid & id_reg_write;
    n.mr = id_valid & id_mem_read;
    n.mw = id_valid & id_mem_write;
    n.m2r = id_valid & id_mem_to_reg;
    n.src = id_alu_src;
    n.wr = id_wr_idx; n.rs = id_rs; n.rt = id_rt;
    n.op = id_alu_operation;
    n.rsv = id_rs_data; n.rtv = id_rt_data;
    n.imm = id_imm;
    return n;
  endfunction

  function automatic ex_t m_next();
    ex_t n;
    logic [31:0] fr, ft;
    fr = m_fwd(m.rs, m.rsv);
    ft = m_fwd(m.rt, m.rtv);
    n = m;
    if (flush || m_hazard()) begin
      n = from_id();
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
    end else if (stall) begin
      n.rsv = fr;
      n.rtv = ft;
    end else begin
      n = from_id();
    end
    return n;
  endfunction

  task automatic check_all();
    logic [31:0] e_store, e_in2;
    check("hazard_hold", 32'(hazard_hold), 32'(m_hazard()));
    check("ex_valid", 32'(ex_valid), 32'(m.valid));
    check("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
    check("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
    check("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
    if (m.valid) begin
      e_store = m_fwd(m.rt, m.rtv);
      e_in2 = m.src ? {{16{m.imm[15]}}, m.imm} : e_store;
      check("in1", in1, m_fwd(m.rs, m.rsv));
      check("in2", in2, e_in2);
      check("ex_store_data", ex_store_data, e_store);
      check("alu_operation", 32'(alu_operation), 32'(m.op));
      check("ex_wr_idx", 32'(ex_wr_idx), 32'(m.wr));
      check("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
    end
  endtask

  // driver tasks
  task automatic idle();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_wr_idx = 0; id_alu_operation = 4'b0010;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    stall = 0; flush = 0;
    exm_reg_write = 0; exm_wr_idx = 0; exm_result = 0;
    wb_reg_write = 0; wb_wr_idx = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                        input logic src, input logic [3:0] op, input logic [4:0] wr,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alu_src = src; id_alu_operation = op; id_wr_idx = wr;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  // advance one edge; always called at a negedge with inputs settled
  task automatic step();
    m = m_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  rs, rt, wr;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        src;
    logic [3:0]  op;
    logic [31:0] exp_in1, exp_in2, exp_store;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5'd1, 5'd2, 5'd10, 32'h1234_5678, 32'h0000_0009, 16'h0004, 1'b0, 4'b0010,
                32'h1234_5678, 32'h0000_0009, 32'h0000_0009};
    vecs[1] = '{5'd3, 5'd4, 5'd11, 32'h0000_0001, 32'h0000_0002, 16'h7FFF, 1'b1, 4'b0010,
                32'h0000_0001, 32'h0000_7FFF, 32'h0000_0002};
    vecs[2] = '{5'd5, 5'd6, 5'd12, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 16'h8000, 1'b1, 4'b0110,
                32'hA5A5_A5A5, 32'hFFFF_8000, 32'h5A5A_5A5A};
    vecs[3] = '{5'd7, 5'd8, 5'd13, 32'h0000_00FF, 32'h0000_0F00, 16'hFFFF, 1'b1, 4'b0000,
                32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0F00};
    vecs[4] = '{5'd0, 5'd0, 5'd14, 32'h0, 32'h0, 16'h1234, 1'b0, 4'b0001,
                32'h0, 32'h0, 32'h0};
    vecs[5] = '{5'd31, 5'd30, 5'd15, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'h0000, 1'b0, 4'b0111,
                32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D};

    idle();
    rst_n = 0;
    m = m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ex_valid", 32'(ex_valid), 32'h0);
    check("reset in1", in1, 32'h0);
    check("reset in2", in2, 32'h0);
    check("reset alu_operation", 32'(alu_operation), 32'h2);
    check("reset hazard_hold", 32'(hazard_hold), 32'h0);
    rst_n = 1;

    // vector table: one instruction per edge, no writers active
    for (int i = 0; i < 6; i++) begin
      set_id(1, vecs[i].rs, vecs[i].rt, vecs[i].rsd, vecs[i].rtd, vecs[i].imm, vecs[i].src,
             vecs[i].op, vecs[i].wr, 0, 0, 0, 0);
      step();
      check("vec in1", in1, vecs[i].exp_in1);
      check("vec in2", in2, vecs[i].exp_in2);
      check("vec store", ex_store_data, vecs[i].exp_store);
      check("vec alu_operation", 32'(alu_operation), 32'(vecs[i].op));
      check("vec ex_valid", 32'(ex_valid), 32'h1);
      check("vec ex_wr_idx", 32'(ex_wr_idx), 32'(vecs[i].wr));
    end

    // stall holds contents while ID changes
    idle(); step();
    set_id(1, 5'd4, 5'd5, 32'h44, 32'h55, 16'h0, 0, 4'b0010, 5'd9, 0, 0, 0, 0);
    step();
    set_id(1, 5'd6, 5'd7, 32'h66, 32'h77, 16'h0, 0, 4'b0110, 5'd10, 0, 0, 0, 0);
    stall = 1;
    step();
    check("stall hold in1", in1, 32'h44);
    check("stall hold alu_operation", 32'(alu_operation), 32'h2);
    stall = 0;
    step();
    check("stall release in1", in1, 32'h66);

    // flush and stall on the same edge: bubble wins
    idle(); step();
    set_id(1, 5'd1, 5'd2, 32'h1, 32'h2, 16'h8000, 1, 4'b0010, 5'd3, 1, 0, 0, 0);
    step();
    check("sext in2", in2, 32'hFFFF_8000);
    flush = 1; stall = 1;
    step();
    check("flush ex_valid", 32'(ex_valid), 32'h0);
    check("flush ex_reg_write", 32'(ex_reg_write), 32'h0);
    check("flush in2", in2, 32'hFFFF_8000);
    flush = 0; stall = 0;

`ifdef ID_EX_FWD_EN
    // EX/MEM beats MEM/WB
    idle(); step();
    set_id(1, 5'd5, 5'd6, 32'h5, 32'h6, 16'h0, 0, 4'b0010, 5'd7, 1, 0, 0, 0);
    step();
    exm_reg_write = 1; exm_wr_idx = 5; exm_result = 32'h11;
    wb_reg_write = 1; wb_wr_idx = 5; wb_data = 32'h22;
    #1 check("fwd exm priority in1", in1, 32'h11);
    exm_reg_write = 0;
    #1 check("fwd wb in1", in1, 32'h22);

    // load-use: bubble, then retry picks up memory data from WB
    idle(); step();
    set_id(1, 5'd1, 5'd0, 32'h1000, 32'h0, 16'h0, 1, 4'b0010, 5'd3, 1, 1, 0, 1);
    step();
    set_id(1, 5'd3, 5'd4, 32'h0, 32'h4, 16'h0, 0, 4'b0010, 5'd8, 1, 0, 0, 0);
    #1 check("load-use hazard_hold", 32'(hazard_hold), 32'h1);
    step();
    check("load-use bubble", 32'(ex_valid), 32'h0);
    exm_reg_write = 1; exm_wr_idx = 3; exm_result = 32'h1000;
    #1 check("load-use retry hold", 32'(hazard_hold), 32'h0);
    step();
    exm_reg_write = 0;
    wb_reg_write = 1; wb_wr_idx = 3; wb_data = 32'hBEEF;
    #1 check("load-use fwd in1", in1, 32'hBEEF);
    check("load-use ex_valid", 32'(ex_valid), 32'h1);

    // r0 is never forwarded and never causes a hold
    idle(); step();
    set_id(1, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 0, 4'b0010, 5'd0, 1, 1, 0, 1);
    step();
    exm_reg_write = 1; exm_wr_idx = 0; exm_result = 32'hFFFF_FFFF;
    set_id(1, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 0, 4'b0010, 5'd2, 1, 0, 0, 0);
    #1 check("r0 in1", in1, 32'h0);
    check("r0 hazard_hold", 32'(hazard_hold), 32'h0);

    // stall refresh captures a WB result for the store data
    idle(); step();
    set_id(1, 5'd2, 5'd9, 32'h100, 32'h1, 16'h4, 1, 4'b0010, 5'd9, 0, 0, 1, 0);
    step();
    set_id(1, 5'd11, 5'd12, 32'h0, 32'h0, 16'h0, 0, 4'b0010, 5'd13, 1, 0, 0, 0);
    stall = 1;
    step();
    wb_reg_write = 1; wb_wr_idx = 9; wb_data = 32'hABCD;
    step();
    wb_reg_write = 0;
    step();
    stall = 0;
    #1 check("stall refresh store", ex_store_data, 32'hABCD);
`else
    // without forwarding every in-flight producer holds ID
    idle(); step();
    set_id(1, 5'd1, 5'd2, 32'h1, 32'h2, 16'h0, 0, 4'b0010, 5'd7, 1, 0, 0, 0);
    step();
    set_id(1, 5'd7, 5'd3, 32'h0, 32'h3, 16'h0, 0, 4'b0010, 5'd8, 1, 0, 0, 0);
    #1 check("ex producer hazard_hold", 32'(hazard_hold), 32'h1);
    step();
    check("hazard bubble", 32'(ex_valid), 32'h0);
    exm_reg_write = 1; exm_wr_idx = 7;
    #1 check("exm producer hazard_hold", 32'(hazard_hold), 32'h1);
    step();
    exm_reg_write = 0;
    id_rs_data = 32'h77;
    #1 check("drained hazard_hold", 32'(hazard_hold), 32'h0);
    step();
    check("retry ex_valid", 32'(ex_valid), 32'h1);
    check("retry in1", in1, 32'h77);
`endif

    // asynchronous reset in mid-cycle drops the in-flight instruction
    idle(); step();
    set_id(1, 5'd3, 5'd4, 32'h3333, 32'h4444, 16'h0, 0, 4'b0110, 5'd5, 1, 0, 0, 0);
    step();
    check("pre-reset ex_valid", 32'(ex_valid), 32'h1);
    idle();
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("async reset ex_valid", 32'(ex_valid), 32'h0);
    check("async reset in1", in1, 32'h0);
    check("async reset in2", in2, 32'h0);
    check("async reset alu_operation", 32'(alu_operation), 32'h2);
    check("async reset hazard_hold", 32'(hazard_hold), 32'h0);
    m = m_reset();
    @(negedge clk);
    rst_n = 1;

    // random run against the model
    for (int c = 0; c < 500; c++) begin
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rs_data = (id_rs == 0) ? 32'h0 : $urandom;
      id_rt_data = (id_rt == 0) ? 32'h0 : $urandom;
      id_imm = 16'($urandom);
      id_alu_src = 1'($urandom_range(0, 1));
      id_alu_operation = 4'($urandom);
      id_wr_idx = 5'($urandom_range(0, 3));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read = 1'($urandom_range(0, 1));
      id_mem_write = 1'($urandom_range(0, 1));
      id_mem_to_reg = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exm_reg_write = 1'($urandom_range(0, 1));
      exm_wr_idx = 5'($urandom_range(0, 3));
      exm_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_wr_idx = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      #1 check_all();
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
